// File: rtl/regbus_pkg.sv
// ---------------------------------------------------------------------------
// regbus_pkg
// Shared types and constants for the register-bus arbiter slice.
//   REGBUS_ADDR_W  : register address width
//   REGBUS_DATA_W  : register data width
//   TRACE_SEL      : addr[5:4] pattern that selects the trace-RAM window
//   regbus_state_e : transaction FSM states
//   is_trace_addr  : helper, 1 when an address falls in the trace window
// ---------------------------------------------------------------------------
package regbus_pkg;

  localparam int REGBUS_ADDR_W = 6;
  localparam int REGBUS_DATA_W = 8;
  localparam logic [1:0] TRACE_SEL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } regbus_state_e;

  function automatic logic is_trace_addr(input logic [REGBUS_ADDR_W-1:0] addr);
    return (addr[REGBUS_ADDR_W-1 -: 2] == TRACE_SEL);
  endfunction

endpackage

// File: rtl/regbus_arb_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with an optional burst lock for port 0.
// Grants are combinational; the pointer (and lock counter) advance only
// when the owner accepts the grant.
// Optional feature macro: REGBUS_ARB_LOCK_EN (port-0 burst lock).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   valid0/valid1  : request pending on port 0 / port 1
//   lock0          : port 0 asks to keep the grant (burst)
//   accept         : the current grant is being taken this cycle
//   gnt0/gnt1      : one-hot grant (both 0 when nothing is eligible)
// ---------------------------------------------------------------------------
module rr_arb2
  import regbus_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic lock0,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);

  // 1 = port 1 was granted last, so port 0 wins the next tie.
  logic last1_r;
  logic rr_gnt0_s;
  logic rr_gnt1_s;

  // Plain round-robin decision.
  always_comb begin
    rr_gnt0_s = 1'b0;
    rr_gnt1_s = 1'b0;
    if (valid0 && valid1) begin
      rr_gnt0_s = last1_r;
      rr_gnt1_s = ~last1_r;
    end else begin
      rr_gnt0_s = valid0;
      rr_gnt1_s = valid1;
    end
  end

  // Round-robin pointer; reset value gives port 0 priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      last1_r <= 1'b1;
    end else if (accept) begin
      last1_r <= gnt1;
    end else begin
      last1_r <= last1_r;
    end
  end

`ifdef REGBUS_ARB_LOCK_EN
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX_C = LOCK_W'(LOCK_MAX);

  logic [LOCK_W-1:0] lock_cnt_r;
  logic              lock_hold_s;
  logic              lock_yield_s;

  // Lock qualifiers: hold port 0 mid-burst, force one port-1 turn at the limit.
  always_comb begin
    lock_hold_s  = lock0 && (lock_cnt_r != {LOCK_W{1'b0}}) && (lock_cnt_r < LOCK_MAX_C);
    lock_yield_s = (lock_cnt_r == LOCK_MAX_C);
  end

  // Final grant: lock overrides round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_hold_s) begin
      gnt0 = valid0;
      gnt1 = 1'b0;
    end else if (lock_yield_s && valid1) begin
      gnt0 = 1'b0;
      gnt1 = 1'b1;
    end else begin
      gnt0 = rr_gnt0_s;
      gnt1 = rr_gnt1_s;
    end
  end

  // Consecutive locked port-0 grants; saturates at the limit until port 1 is served.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_r <= {LOCK_W{1'b0}};
    end else if (accept) begin
      if (gnt0 && lock0) begin
        lock_cnt_r <= (lock_cnt_r == LOCK_MAX_C) ? lock_cnt_r : lock_cnt_r + LOCK_W'(1);
      end else begin
        lock_cnt_r <= {LOCK_W{1'b0}};
      end
    end else begin
      lock_cnt_r <= lock_cnt_r;
    end
  end
`else
  // Lock request and limit have no function in this build.
  logic        unused_lock_s;
  logic [31:0] unused_lock_max_s;
  assign unused_lock_s     = lock0;
  assign unused_lock_max_s = 32'(LOCK_MAX);

  // Final grant is the plain round-robin decision.
  always_comb begin
    gnt0 = rr_gnt0_s;
    gnt1 = rr_gnt1_s;
  end
`endif

endmodule

// File: rtl/regbus_arb.sv
// ---------------------------------------------------------------------------
// regbus_arb
// Arbitrates two requesters onto a single register-file port, one
// transaction at a time: IDLE (accept) -> ISSUE (strobe) -> WAIT (reads
// only, RD_LAT cycles) -> RESP (completion pulse).
// Optional feature macro: REGBUS_ARB_LOCK_EN (port-0 burst lock, see rr_arb2).
// Parameters:
//   RD_LAT   : register-file read latency in cycles (1..4)
//   LOCK_MAX : maximum consecutive locked grants to port 0
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata   : request from requester N (N=0,1)
//   reqN_ready                 : request accepted this cycle (combinational)
//   rspN_valid/rspN_rdata      : one-cycle completion with read data
//   req0_lock                  : port 0 burst-lock request
//   reg_addr/rd/wr/wdata       : register-file command
//   reg_rdata                  : register-file read data, RD_LAT after reg_rd
//   trace_pop                  : pop pulse after a read of 0x30-0x3F
// ---------------------------------------------------------------------------
module regbus_arb
  import regbus_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic                     req0_we,
  input  logic [REGBUS_ADDR_W-1:0] req0_addr,
  input  logic [REGBUS_DATA_W-1:0] req0_wdata,
  output logic                     req0_ready,
  output logic                     rsp0_valid,
  output logic [REGBUS_DATA_W-1:0] rsp0_rdata,
  input  logic                     req1_valid,
  input  logic                     req1_we,
  input  logic [REGBUS_ADDR_W-1:0] req1_addr,
  input  logic [REGBUS_DATA_W-1:0] req1_wdata,
  output logic                     req1_ready,
  output logic                     rsp1_valid,
  output logic [REGBUS_DATA_W-1:0] rsp1_rdata,
  input  logic                     req0_lock,
  output logic [REGBUS_ADDR_W-1:0] reg_addr,
  output logic                     reg_rd,
  output logic                     reg_wr,
  output logic [REGBUS_DATA_W-1:0] reg_wdata,
  input  logic [REGBUS_DATA_W-1:0] reg_rdata,
  output logic                     trace_pop
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  regbus_state_e state_r;
  regbus_state_e state_next_s;

  logic                     gnt0_s;
  logic                     gnt1_s;
  logic                     accept_s;
  logic                     sel_we_s;
  logic [REGBUS_ADDR_W-1:0] sel_addr_s;
  logic [REGBUS_DATA_W-1:0] sel_wdata_s;
  logic                     rd_done_s;
  logic                     rsp_fire_s;
  logic [REGBUS_DATA_W-1:0] rsp_data_s;

  logic                     txn_we_r;
  logic                     txn_port_r;   // 0 = port 0, 1 = port 1
  logic [2:0]               wait_cnt_r;
  logic [REGBUS_ADDR_W-1:0] reg_addr_r;
  logic [REGBUS_DATA_W-1:0] reg_wdata_r;
  logic                     reg_rd_r;
  logic                     reg_wr_r;
  logic                     rsp0_valid_r;
  logic                     rsp1_valid_r;
  logic [REGBUS_DATA_W-1:0] rsp0_rdata_r;
  logic [REGBUS_DATA_W-1:0] rsp1_rdata_r;
  logic                     trace_pop_r;

  rr_arb2 #(
    .LOCK_MAX (LOCK_MAX)
  ) u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .lock0  (req0_lock),
    .accept (accept_s),
    .gnt0   (gnt0_s),
    .gnt1   (gnt1_s)
  );

  // Accept only in IDLE; gated by reset so ready is 0 while reset is held.
  always_comb begin
    accept_s = 1'b0;
    if (!reset && (state_r == ST_IDLE)) begin
      accept_s = gnt0_s | gnt1_s;
    end else begin
      accept_s = 1'b0;
    end
  end

  assign req0_ready = accept_s & gnt0_s;
  assign req1_ready = accept_s & gnt1_s;

  // Request fields of the granted port.
  always_comb begin
    sel_we_s    = req0_we;
    sel_addr_s  = req0_addr;
    sel_wdata_s = req0_wdata;
    if (gnt1_s) begin
      sel_we_s    = req1_we;
      sel_addr_s  = req1_addr;
      sel_wdata_s = req1_wdata;
    end else begin
      sel_we_s    = req0_we;
      sel_addr_s  = req0_addr;
      sel_wdata_s = req0_wdata;
    end
  end

  // WAIT is entered with count 1 (the reg_rd cycle is cycle 0), so the
  // last WAIT cycle is the one where reg_rdata is valid.
  assign rd_done_s = (state_r == ST_WAIT) && (wait_cnt_r == RD_LAT_C);

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_ISSUE;
        else          state_next_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (txn_we_r) state_next_s = ST_RESP;
        else          state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_done_s) state_next_s = ST_RESP;
        else           state_next_s = ST_WAIT;
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Values the registered response outputs take on the next edge.
  always_comb begin
    rsp_fire_s = (state_next_s == ST_RESP);
    rsp_data_s = {REGBUS_DATA_W{1'b0}};
    if (rd_done_s) begin
      rsp_data_s = reg_rdata;
    end else begin
      rsp_data_s = {REGBUS_DATA_W{1'b0}};
    end
  end

  // State, transaction latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      txn_we_r     <= 1'b0;
      txn_port_r   <= 1'b0;
      wait_cnt_r   <= 3'd0;
      reg_addr_r   <= {REGBUS_ADDR_W{1'b0}};
      reg_wdata_r  <= {REGBUS_DATA_W{1'b0}};
      reg_rd_r     <= 1'b0;
      reg_wr_r     <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_rdata_r <= {REGBUS_DATA_W{1'b0}};
      rsp1_rdata_r <= {REGBUS_DATA_W{1'b0}};
      trace_pop_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      // reg_addr/reg_wdata double as the transaction latch and hold
      // their last value until the next accept.
      if (accept_s) begin
        txn_we_r    <= sel_we_s;
        txn_port_r  <= gnt1_s;
        reg_addr_r  <= sel_addr_s;
        reg_wdata_r <= sel_wdata_s;
      end
      reg_rd_r <= accept_s & ~sel_we_s;
      reg_wr_r <= accept_s & sel_we_s;
      if (state_r == ST_ISSUE)     wait_cnt_r <= 3'd1;
      else if (state_r == ST_WAIT) wait_cnt_r <= wait_cnt_r + 3'd1;
      else                         wait_cnt_r <= 3'd0;
      rsp0_valid_r <= rsp_fire_s & ~txn_port_r;
      rsp1_valid_r <= rsp_fire_s & txn_port_r;
      rsp0_rdata_r <= (rsp_fire_s & ~txn_port_r) ? rsp_data_s : {REGBUS_DATA_W{1'b0}};
      rsp1_rdata_r <= (rsp_fire_s & txn_port_r) ? rsp_data_s : {REGBUS_DATA_W{1'b0}};
      trace_pop_r  <= rsp_fire_s & ~txn_we_r & is_trace_addr(reg_addr_r);
    end
  end

  assign reg_addr   = reg_addr_r;
  assign reg_wdata  = reg_wdata_r;
  assign reg_rd     = reg_rd_r;
  assign reg_wr     = reg_wr_r;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_rdata = rsp0_rdata_r;
  assign rsp1_rdata = rsp1_rdata_r;
  assign trace_pop  = trace_pop_r;

endmodule

// File: doc/regbus_arb.md
REGBUS_ARB -- requirements
Module: regbus_arb

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 1, meaning register-file read latency in clk cycles (legal 1..4).
REQ-002 The block SHALL have parameter LOCK_MAX, default 16, meaning maximum consecutive locked grants to port 0.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N has a pending transaction.
REQ-006 reqN_we  input  1  1=write, 0=read.
REQ-007 reqN_addr  input  6  register address.
REQ-008 reqN_wdata  input  8  write data.
REQ-009 reqN_ready  output  1  request accepted this cycle.
REQ-010 rspN_valid  output  1  one-cycle completion pulse to requester N.
REQ-011 rspN_rdata  output  8  read data, valid with rspN_valid; 0 for writes.
REQ-012 req0_lock  input  1  port 0 requests grant retention (burst).
REQ-013 reg_addr  output  6  register-file address.
REQ-014 reg_rd  output  1  one-cycle read strobe.
REQ-015 reg_wr  output  1  one-cycle write strobe.
REQ-016 reg_wdata  output  8  write data to register file.
REQ-017 reg_rdata  input  8  register-file read data, valid RD_LAT cycles after reg_rd.
REQ-018 trace_pop  output  1  one-cycle pop to trace RAM after a read of addresses 0x30-0x3F.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if any reqN_valid, arbiter selects one, pulses reqN_ready for that port only (combinational, same cycle), latches we/addr/wdata, goes to ISSUE; else stays IDLE.
REQ-021 Arbitration SHALL be round-robin: on simultaneous valid, the port not granted last wins; after reset port 0 has priority.
REQ-022 ISSUE: drive latched addr/wdata on reg_*, assert reg_wr (write) or reg_rd (read) exactly one cycle; write goes to RESP, read goes to WAIT.
REQ-023 WAIT: count RD_LAT cycles from the reg_rd cycle, capture reg_rdata on the last, then go to RESP.
REQ-024 RESP: pulse rspN_valid for the granted port with captured data (0 for writes), return to IDLE.
REQ-025 Latency SHALL be: accept at cycle T, response at T+2 for writes, T+2+RD_LAT for reads.
REQ-026 Only one transaction SHALL be outstanding; reqN_ready SHALL be 0 outside IDLE.
REQ-027 trace_pop SHALL pulse in RESP when the completed transaction was a read with addr[5:4]==2'b11; never for writes.
REQ-028 reg_addr/reg_wdata SHALL hold last-issued values outside ISSUE; reg_rd/reg_wr SHALL be 0 outside ISSUE.
REQ-029 A requester deasserting valid while not in IDLE SHALL have no effect on the in-flight transaction.

Reset
REQ-030 On reset all outputs SHALL be 0, FSM to IDLE, round-robin pointer to port-0-priority, lock counter to 0, captured data to 0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no rspN_valid and no trace_pop.

Configuration
REQ-032 Macro REGBUS_ARB_LOCK_EN defined: a grant to port 0 with req0_lock=1 SHALL make port 0 sole eligible in the following IDLE cycles while req0_lock=1, up to LOCK_MAX consecutive grants, after which port 1 (if valid) SHALL be granted once and the count SHALL clear.
REQ-033 Macro REGBUS_ARB_LOCK_EN undefined: req0_lock SHALL be ignored and the lock counter SHALL not exist.

Structure
REQ-034 Package regbus_pkg SHALL hold the FSM state enum, REGBUS_ADDR_W=6, REGBUS_DATA_W=8, TRACE_SEL=2'b11.
REQ-035 Arbitration decision and pointer SHALL be sub-module rr_arb2 (2-way round-robin with lock qualifier).

Verification
REQ-036 Port 0 write 0x05<=0xA5 alone -> reg_wr at T+1 with addr 0x05/data 0xA5, rsp0_valid at T+2, rsp0_rdata 0x00.
REQ-037 Port 1 read 0x12, RD_LAT=2, reg_rdata=0x3C -> reg_rd at T+1, rsp1_valid at T+4 with 0x3C, no trace_pop.
REQ-038 Both ports valid continuously after reset -> grants alternate 0,1,0,1; no two readys in one cycle.
REQ-039 Port 0 read 0x31 -> trace_pop pulses once, same cycle as rsp0_valid.
REQ-040 With REGBUS_ARB_LOCK_EN, LOCK_MAX=4, req0_lock=1, both valid -> four port-0 grants, then one port-1 grant.
REQ-041 Reset asserted during WAIT -> no rsp pulse, all outputs 0 next cycle, next simultaneous request grants port 0.
